tse_ddr_bridge_arbiter: RTL and testbench
=========================================

TSE_DDR_BRIDGE_ARBITER -- requirements
Module: tse_ddr_bridge_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24: word-address width on all ports.
REQ-002 Parameter MAX_PENDING, default 8, power of two, 2..32: maximum reads accepted but not yet returned.
REQ-003 clk  in  1  single clock for all ports.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 a_address/a_byteenable/a_writedata  in  ADDR_W/4/32  requester A command fields.
REQ-006 a_read, a_write  in  1  requester A strobes, held stable while a_waitrequest=1.
REQ-007 a_waitrequest  out  1  requester A stall; a_readdata  out  32; a_readdatavalid  out  1.
REQ-008 b_* ports are identical to a_* (REQ-005..007) for requester B.
REQ-009 m_address/m_byteenable/m_writedata  out  ADDR_W/4/32  command toward the DDR clock bridge slave.
REQ-010 m_read, m_write  out  1; m_waitrequest  in  1; m_readdata  in  32; m_readdatavalid  in  1.
REQ-011 err_orphan  out  1  sticky flag: read response arrived with no read pending.

Function
REQ-012 FSM states: IDLE, HOLD_A, HOLD_B.
REQ-013 IDLE: select one eligible requester; drive its command combinationally onto m_*.
REQ-014 Eligibility: write strobe asserted; or read strobe asserted and pending count < MAX_PENDING.
REQ-015 Simultaneous eligibility: round-robin; the port not granted last wins; after reset, A wins.
REQ-016 IDLE, selection made, m_waitrequest=0: transfer completes this cycle; requester waitrequest=0; state stays IDLE.
REQ-017 IDLE, selection made, m_waitrequest=1: next state HOLD_x.
REQ-018 HOLD_x: m_* follow requester x only; the other requester is stalled.
REQ-019 HOLD_x, m_waitrequest=0: transfer completes; next state IDLE.
REQ-020 Requester waitrequest is 1 whenever its transfer does not complete in that cycle, including when it is ineligible.
REQ-021 Requester waitrequest is 1 while the requester is idle (strobes low).
REQ-022 m_read and m_write are 0 whenever no requester is selected.
REQ-023 Round-robin "last granted" updates only on a completed transfer.
REQ-024 Ordering FIFO: MAX_PENDING entries x 1 bit.
REQ-025 FIFO push: requester ID on each completed read.
REQ-026 FIFO pop: on each m_readdatavalid.
REQ-027 Pending count = FIFO occupancy; push and pop in the same cycle leave the count unchanged.
REQ-028 Count = MAX_PENDING with a same-cycle pop: a read is still ineligible (count is registered).
REQ-029 a_readdata = b_readdata = m_readdata, no added latency.
REQ-030 x_readdatavalid = m_readdatavalid AND FIFO head == x, same cycle.
REQ-031 m_readdatavalid with FIFO empty: no readdatavalid to either requester; err_orphan set until reset; FIFO unchanged.
REQ-032 A requester asserting read and write together is treated as a write; read is ignored.

Reset
REQ-033 Reset asserted: state=IDLE, FIFO empty, last-granted=B, err_orphan=0.
REQ-034 While reset is asserted, all m_* strobes and requester readdatavalid outputs are 0; waitrequest outputs are 1.
REQ-035 Reset mid-HOLD or with reads pending: all pending reads are discarded; no responses routed after release until new reads are accepted.

Configuration
REQ-036 Macro TSE_DDR_BRIDGE_ARBITER_FIXED_PRIORITY_EN defined: REQ-015 replaced by fixed priority, A always wins; last-granted register removed.
REQ-037 Macro undefined: round-robin per REQ-015 and REQ-023.

Verification
REQ-038 A and B write every cycle, m_waitrequest=0 -> grants alternate A,B,A,B; A first after reset (fixed-priority build: A only, B stalled).
REQ-039 A write 0x000010 data 0xDEADBEEF, m_waitrequest=1 for 3 cycles, B requesting -> m_* hold A's command 4 cycles, B stalled, then B granted.
REQ-040 Reads A,B,A,B issued; m_readdatavalid returns 0x11,0x22,0x33,0x44 -> A gets 0x11,0x33; B gets 0x22,0x44.
REQ-041 A issues 9 reads, MAX_PENDING=8, no responses -> 9th stalls; first response -> 9th accepted the following cycle.
REQ-042 m_readdatavalid pulse with no read pending -> no requester readdatavalid; err_orphan=1 until reset_n low.
REQ-043 reset_n low during HOLD_B with 3 reads pending -> IDLE, count 0, strobes 0; later m_readdatavalid sets err_orphan.

Source files
------------

// File: rtl/tse_ddr_bridge_arbiter.sv
// Two-requester arbiter in front of the TSE DDR clock-bridge slave, with in-order read-response routing.
// Define TSE_DDR_BRIDGE_ARBITER_FIXED_PRIORITY_EN for fixed A-over-B priority instead of round-robin.
module tse_ddr_bridge_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_byteenable,
  input  logic [31:0]       a_writedata,
  input  logic              a_read,
  input  logic              a_write,
  output logic              a_waitrequest,
  output logic [31:0]       a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [3:0]        b_byteenable,
  input  logic [31:0]       b_writedata,
  input  logic              b_read,
  input  logic              b_write,
  output logic              b_waitrequest,
  output logic [31:0]       b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  output logic              m_read,
  output logic              m_write,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              err_orphan
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, HOLD_A, HOLD_B} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   pend_cnt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [MAX_PENDING-1:0] id_fifo;
  logic               room, a_elig, b_elig, win_a;
  logic               sel_a, sel_b, xfer_done, push, pop, head_b;

  // Count is registered, so a pop in the same cycle does not free a slot yet.
  assign room   = pend_cnt < CNT_W'(MAX_PENDING);
  assign a_elig = a_write | (a_read & room);
  assign b_elig = b_write | (b_read & room);

`ifdef TSE_DDR_BRIDGE_ARBITER_FIXED_PRIORITY_EN
  assign win_a = a_elig;
`else
  logic last_b;
  assign win_a = a_elig & (~b_elig | last_b);
`endif

  always_comb begin
    state_nxt = state;
    sel_a     = 1'b0;
    sel_b     = 1'b0;
    case (state)
      IDLE: begin
        if (win_a)       sel_a = 1'b1;
        else if (b_elig) sel_b = 1'b1;
        if ((sel_a | sel_b) && m_waitrequest)
          state_nxt = sel_a ? HOLD_A : HOLD_B;
      end
      HOLD_A: begin
        sel_a = 1'b1;
        if (!m_waitrequest) state_nxt = IDLE;
      end
      HOLD_B: begin
        sel_b = 1'b1;
        if (!m_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write wins when a requester raises both strobes; everything is gated off while in reset.
  always_comb begin
    m_address     = sel_b ? b_address    : a_address;
    m_byteenable  = sel_b ? b_byteenable : a_byteenable;
    m_writedata   = sel_b ? b_writedata  : a_writedata;
    m_write       = reset_n & ((sel_a & a_write) | (sel_b & b_write));
    m_read        = reset_n & ((sel_a & a_read & ~a_write) | (sel_b & b_read & ~b_write));
    xfer_done     = reset_n & (sel_a | sel_b) & ~m_waitrequest;
    a_waitrequest = ~(xfer_done & sel_a);
    b_waitrequest = ~(xfer_done & sel_b);
    push          = xfer_done & m_read;
    pop           = m_readdatavalid & (pend_cnt != '0);
    head_b        = id_fifo[rd_ptr];
    a_readdata    = m_readdata;
    b_readdata    = m_readdata;
    a_readdatavalid = pop & ~head_b;
    b_readdatavalid = pop & head_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
      if (m_readdatavalid && pend_cnt == '0) err_orphan <= 1'b1;
    end
  end

`ifndef TSE_DDR_BRIDGE_ARBITER_FIXED_PRIORITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       last_b <= 1'b1;
    else if (xfer_done) last_b <= sel_b;
  end
`endif

  // Requester IDs are data: validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) id_fifo[wr_ptr] <= sel_b;
  end

endmodule

// File: tb/tb_tse_ddr_bridge_arbiter.sv
// Self-checking bench for tse_ddr_bridge_arbiter: vector table, directed corner sequences, randomized run against a queue model.
module tb_tse_ddr_bridge_arbiter;

  localparam int ADDR_W = 24;
  localparam int MAXP   = 8;
  localparam logic [23:0] A_ADDR = 24'h000010;
  localparam logic [23:0] B_ADDR = 24'h000020;
  localparam logic [31:0] A_DATA = 32'hDEADBEEF;
  localparam logic [31:0] B_DATA = 32'hB0B0B0B0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ADDR_W-1:0] a_address, b_address, m_address;
  logic [3:0]  a_byteenable, b_byteenable, m_byteenable;
  logic [31:0] a_writedata, b_writedata, m_writedata;
  logic a_read, a_write, a_waitrequest, a_readdatavalid;
  logic b_read, b_write, b_waitrequest, b_readdatavalid;
  logic [31:0] a_readdata, b_readdata, m_readdata;
  logic m_read, m_write, m_waitrequest, m_readdatavalid, err_orphan;

  int checks = 0;
  int errors = 0;

  tse_ddr_bridge_arbiter #(.ADDR_W(ADDR_W), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_read(a_read), .a_write(a_write), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_read(b_read), .b_write(b_write), .b_waitrequest(b_waitrequest),
    .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    a_address = A_ADDR; a_writedata = A_DATA; a_byteenable = 4'hF;
    b_address = B_ADDR; b_writedata = B_DATA; b_byteenable = 4'h3;
    m_waitrequest = 0; m_readdatavalid = 0; m_readdata = 32'h0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1;
  endtask

  typedef struct {
    logic ar, aw, br, bw, mwait;
    int   sel;
    logic mr, mw, awr, bwr;
  } vec_t;

  vec_t tbl[14];

  // Random-phase requester state
  typedef struct {
    logic        active, rd, wr;
    logic [23:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  req_t ra, rb;
  int   pend_q[$];
  int   hold, sel;
  logic last_b, orphan, a_el, b_el, done, exp_rdv_a, exp_rdv_b;

  initial begin
    // Reset state with a requester already knocking
    idle_inputs();
    a_write = 1; b_read = 1; m_readdatavalid = 1;
    #4;
    chk("rst_m_write", m_write, 0);
    chk("rst_m_read", m_read, 0);
    chk("rst_a_wait", a_waitrequest, 1);
    chk("rst_b_wait", b_waitrequest, 1);
    chk("rst_a_rdv", a_readdatavalid, 0);
    chk("rst_b_rdv", b_readdatavalid, 0);
    chk("rst_orphan", err_orphan, 0);
    do_reset();

    // ar aw br bw mwait | sel mr mw awr bwr
    tbl[0]  = '{0,0,0,0,0, 0, 0,0, 1,1};
    tbl[1]  = '{0,1,0,1,0, 1, 0,1, 0,1};
    tbl[2]  = '{0,1,0,1,0, 2, 0,1, 1,0};
    tbl[3]  = '{0,1,0,1,0, 1, 0,1, 0,1};
    tbl[4]  = '{0,1,0,1,0, 2, 0,1, 1,0};
    tbl[5]  = '{0,1,0,1,1, 1, 0,1, 1,1};
    tbl[6]  = '{0,1,0,1,1, 1, 0,1, 1,1};
    tbl[7]  = '{0,1,0,1,1, 1, 0,1, 1,1};
    tbl[8]  = '{0,1,0,1,0, 1, 0,1, 0,1};
    tbl[9]  = '{0,0,0,1,0, 2, 0,1, 1,0};
    tbl[10] = '{0,0,0,1,1, 2, 0,1, 1,1};
    tbl[11] = '{0,1,0,1,0, 2, 0,1, 1,0};
    tbl[12] = '{1,1,0,0,0, 1, 0,1, 0,1};
    tbl[13] = '{0,0,0,0,0, 0, 0,0, 1,1};
    for (int i = 0; i < 14; i++) begin
      a_read = tbl[i].ar; a_write = tbl[i].aw;
      b_read = tbl[i].br; b_write = tbl[i].bw;
      m_waitrequest = tbl[i].mwait;
      #4;
      chk($sformatf("tbl%0d_m_read", i), m_read, tbl[i].mr);
      chk($sformatf("tbl%0d_m_write", i), m_write, tbl[i].mw);
      chk($sformatf("tbl%0d_a_wait", i), a_waitrequest, tbl[i].awr);
      chk($sformatf("tbl%0d_b_wait", i), b_waitrequest, tbl[i].bwr);
      if (tbl[i].sel == 1) begin
        chk($sformatf("tbl%0d_addrA", i), m_address, A_ADDR);
        chk($sformatf("tbl%0d_dataA", i), m_writedata, A_DATA);
      end else if (tbl[i].sel == 2) begin
        chk($sformatf("tbl%0d_addrB", i), m_address, B_ADDR);
        chk($sformatf("tbl%0d_beB", i), m_byteenable, 4'h3);
      end
      tick();
    end

    // Interleaved reads routed back in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_read = (i % 2 == 0); b_read = (i % 2 == 1);
      #4;
      chk($sformatf("rd%0d_m_read", i), m_read, 1);
      chk($sformatf("rd%0d_wait", i), (i % 2 == 0) ? a_waitrequest : b_waitrequest, 0);
      tick();
    end
    a_read = 0; b_read = 0;
    for (int i = 0; i < 4; i++) begin
      m_readdatavalid = 1; m_readdata = 32'h11 * (i + 1);
      #4;
      chk($sformatf("rsp%0d_a_rdv", i), a_readdatavalid, (i % 2 == 0));
      chk($sformatf("rsp%0d_b_rdv", i), b_readdatavalid, (i % 2 == 1));
      chk($sformatf("rsp%0d_data", i), (i % 2 == 0) ? a_readdata : b_readdata, 32'h11 * (i + 1));
      tick();
    end
    m_readdatavalid = 0;
    #4;
    chk("rsp_no_orphan", err_orphan, 0);

    // Full pending window: ninth read stalls until a response drains one slot
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a_read = 1; a_address = 24'(i);
      #4;
      chk($sformatf("full%0d_accept", i), a_waitrequest, 0);
      tick();
    end
    a_address = 24'h9;
    #4;
    chk("full9_stall", a_waitrequest, 1);
    chk("full9_m_read", m_read, 0);
    tick();
    m_readdatavalid = 1; m_readdata = 32'h55;
    #4;
    chk("full9_stall_on_pop", a_waitrequest, 1);
    chk("full9_pop_rdv", a_readdatavalid, 1);
    tick();
    m_readdatavalid = 0;
    #4;
    chk("full9_accept", a_waitrequest, 0);
    tick();
    a_read = 0;

    // Orphan response
    do_reset();
    m_readdatavalid = 1; m_readdata = 32'h77;
    #4;
    chk("orph_a_rdv", a_readdatavalid, 0);
    chk("orph_b_rdv", b_readdatavalid, 0);
    tick();
    m_readdatavalid = 0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk($sformatf("orph_sticky%0d", i), err_orphan, 1);
      tick();
    end
    reset_n = 0;
    #1;
    chk("orph_clear", err_orphan, 0);
    tick();
    reset_n = 1;

    // Reset while holding B with reads pending
    for (int i = 0; i < 3; i++) begin
      b_read = 1;
      #4;
      chk($sformatf("hr_rd%0d", i), b_waitrequest, 0);
      tick();
    end
    b_read = 0; b_write = 1; m_waitrequest = 1;
    #4;
    chk("hr_m_write", m_write, 1);
    tick();
    a_write = 1;
    #2;
    chk("hr_hold_addr", m_address, B_ADDR);
    chk("hr_a_stalled", a_waitrequest, 1);
    reset_n = 0;
    #1;
    chk("hr_rst_m_write", m_write, 0);
    chk("hr_rst_m_read", m_read, 0);
    chk("hr_rst_b_wait", b_waitrequest, 1);
    chk("hr_rst_a_wait", a_waitrequest, 1);
    tick();
    reset_n = 1;
    idle_inputs();
    m_readdatavalid = 1;
    #4;
    chk("hr_no_a_rdv", a_readdatavalid, 0);
    chk("hr_no_b_rdv", b_readdatavalid, 0);
    tick();
    m_readdatavalid = 0;
    #4;
    chk("hr_orphan", err_orphan, 1);

    // Randomized traffic against a queue-based model
    do_reset();
    ra = '{0,0,0,24'h0,32'h0,4'h0};
    rb = ra;
    pend_q.delete();
    hold = 0; last_b = 1; orphan = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ra.active && $urandom_range(0, 1) == 1) begin
        int k = $urandom_range(0, 3);
        ra = '{1, (k != 1), (k == 1 || k == 2), 24'($urandom), $urandom, 4'($urandom)};
      end
      if (!rb.active && $urandom_range(0, 1) == 1) begin
        int k = $urandom_range(0, 3);
        rb = '{1, (k != 1), (k == 1 || k == 2), 24'($urandom), $urandom, 4'($urandom)};
      end
      a_read = ra.active & ra.rd; a_write = ra.active & ra.wr;
      a_address = ra.addr; a_writedata = ra.data; a_byteenable = ra.be;
      b_read = rb.active & rb.rd; b_write = rb.active & rb.wr;
      b_address = rb.addr; b_writedata = rb.data; b_byteenable = rb.be;
      m_waitrequest = ($urandom_range(0, 2) == 0);
      m_readdatavalid = (pend_q.size() > 0) && ($urandom_range(0, 2) == 0);
      m_readdata = $urandom;

      a_el = ra.active && (ra.wr || (ra.rd && pend_q.size() < MAXP));
      b_el = rb.active && (rb.wr || (rb.rd && pend_q.size() < MAXP));
      if (hold != 0)          sel = hold;
      else if (a_el && b_el)  sel = last_b ? 1 : 2;
      else if (a_el)          sel = 1;
      else if (b_el)          sel = 2;
      else                    sel = 0;
      done = (sel != 0) && !m_waitrequest;
      exp_rdv_a = m_readdatavalid && pend_q.size() > 0 && pend_q[0] == 1;
      exp_rdv_b = m_readdatavalid && pend_q.size() > 0 && pend_q[0] == 2;
      #4;
      chk("rnd_m_write", m_write, (sel == 1) ? ra.wr : (sel == 2) ? rb.wr : 1'b0);
      chk("rnd_m_read", m_read, (sel == 1) ? (ra.rd && !ra.wr) : (sel == 2) ? (rb.rd && !rb.wr) : 1'b0);
      if (sel != 0) begin
        chk("rnd_m_addr", m_address, (sel == 1) ? ra.addr : rb.addr);
        chk("rnd_m_data", m_writedata, (sel == 1) ? ra.data : rb.data);
        chk("rnd_m_be", m_byteenable, (sel == 1) ? ra.be : rb.be);
      end
      chk("rnd_a_wait", a_waitrequest, !(done && sel == 1));
      chk("rnd_b_wait", b_waitrequest, !(done && sel == 2));
      chk("rnd_a_rdv", a_readdatavalid, exp_rdv_a);
      chk("rnd_b_rdv", b_readdatavalid, exp_rdv_b);
      chk("rnd_a_rdata", a_readdata, m_readdata);
      chk("rnd_b_rdata", b_readdata, m_readdata);
      chk("rnd_orphan", err_orphan, orphan);

      if (m_readdatavalid) begin
        if (pend_q.size() > 0) void'(pend_q.pop_front());
        else orphan = 1;
      end
      if (done) begin
        if (sel == 1) begin
          if (ra.rd && !ra.wr) pend_q.push_back(1);
          ra.active = 0;
        end else begin
          if (rb.rd && !rb.wr) pend_q.push_back(2);
          rb.active = 0;
        end
        last_b = (sel == 2);
        hold = 0;
      end else begin
        hold = sel;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
